// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, bus types and in-flight response encoding
// for the IF/EX shared-memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int WORD_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WORD_W-1:0] word_t;

    // In-flight response state: which requester owns the memory reply next cycle.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IF_RD = 2'd1;
    localparam logic [1:0] ST_EX_RD = 2'd2;
    localparam logic [1:0] ST_EX_WR = 2'd3;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bundle for the instruction-fetch port, the
// execute-stage port and the shared single-port memory.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // instruction fetch
    logic  if_req_i;
    addr_t if_addr_i;
    logic  if_gnt_o;
    logic  if_valid_o;
    word_t if_rdata_o;
    // execute-stage data access
    logic  ex_req_i;
    logic  ex_we_i;
    addr_t ex_addr_i;
    word_t ex_wdata_i;
    logic  ex_gnt_o;
    logic  ex_valid_o;
    word_t ex_rdata_o;
    // shared memory
    addr_t mem_a_o;
    logic  mem_w_o;
    word_t mem_d_o;
    word_t mem_q_i;

    // Requesters and memory model side.
    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_valid_o, if_rdata_o,
        output ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i,
        input  ex_gnt_o, ex_valid_o, ex_rdata_o,
        input  mem_a_o, mem_w_o, mem_d_o,
        output mem_q_i
    );

    // Arbiter side.
    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_valid_o, if_rdata_o,
        input  ex_req_i, ex_we_i, ex_addr_i, ex_wdata_i,
        output ex_gnt_o, ex_valid_o, ex_rdata_o,
        output mem_a_o, mem_w_o, mem_d_o,
        input  mem_q_i
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: counts consecutive cycles the fetch port was denied and
// flags when the limit is reached. Only built with ARB_STARVE_GUARD_EN.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_ctr #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic at_max
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] C_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] r_cnt;

    // Saturating denial counter; cleared whenever fetch is idle or served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= {CW{1'b0}};
        end else if (!req || gnt) begin
            r_cnt <= {CW{1'b0}};
        end else if (r_cnt != C_MAX) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign at_max = (r_cnt == C_MAX);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (IF/EX) arbiter for a shared single-port memory with
// registered-read timing. EX has priority; with ARB_STARVE_GUARD_EN defined a
// starvation counter forces IF to win after STARVE_MAX consecutive denials.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    logic       w_if_win;
    logic       w_if_gnt;
    logic       w_ex_gnt;
    logic [1:0] w_state_nxt;
    logic [1:0] r_state;

`ifdef ARB_STARVE_GUARD_EN
    logic w_at_max;

    arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.if_req_i),
        .gnt    (w_if_gnt),
        .at_max (w_at_max)
    );

    assign w_if_win = bus.if_req_i & w_at_max;
`else
    logic w_unused_starve_max;

    assign w_unused_starve_max = (STARVE_MAX > 0);
    assign w_if_win            = 1'b0;
`endif

    // Grant selection: at most one winner, nothing granted while in reset.
    always_comb begin
        w_ex_gnt = 1'b0;
        w_if_gnt = 1'b0;
        if (rst) begin
            w_ex_gnt = bus.ex_req_i & ~w_if_win;
            w_if_gnt = bus.if_req_i & ~w_ex_gnt;
        end else begin
            w_ex_gnt = 1'b0;
            w_if_gnt = 1'b0;
        end
    end

    // Next in-flight state follows the grant made this cycle.
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_ex_gnt) begin
            w_state_nxt = bus.ex_we_i ? ST_EX_WR : ST_EX_RD;
        end else if (w_if_gnt) begin
            w_state_nxt = ST_IF_RD;
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    // In-flight register; reset drops any pending response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory request drive; idle address parks on the fetch address.
    always_comb begin
        bus.mem_a_o = {ADDR_W{1'b0}};
        bus.mem_w_o = 1'b0;
        bus.mem_d_o = {WORD_W{1'b0}};
        if (rst) begin
            bus.mem_a_o = w_ex_gnt ? bus.ex_addr_i : bus.if_addr_i;
            bus.mem_w_o = w_ex_gnt & bus.ex_we_i;
            bus.mem_d_o = bus.ex_wdata_i;
        end else begin
            bus.mem_a_o = {ADDR_W{1'b0}};
            bus.mem_w_o = 1'b0;
            bus.mem_d_o = {WORD_W{1'b0}};
        end
    end

    assign bus.if_gnt_o   = w_if_gnt;
    assign bus.ex_gnt_o   = w_ex_gnt;
    assign bus.if_valid_o = (r_state == ST_IF_RD);
    assign bus.ex_valid_o = (r_state == ST_EX_RD) || (r_state == ST_EX_WR);
    assign bus.if_rdata_o = (r_state == ST_IF_RD) ? bus.mem_q_i : {WORD_W{1'b0}};
    assign bus.ex_rdata_o = (r_state == ST_EX_RD) ? bus.mem_q_i : {WORD_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small
// registered-read memory attached to the shared port.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic        pl_we;
    logic [9:0]  pl_a;
    word_t       pl_d;
    word_t       mem [0:1023];
    word_t       mem_q;
    logic [1:0]  exp_gnt;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single-port memory, read data registered one cycle after the address.
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_a] <= pl_d;
        end else if (bus.mem_w_o) begin
            mem[bus.mem_a_o[9:0]] <= bus.mem_d_o;
        end
        mem_q <= mem[bus.mem_a_o[9:0]];
    end

    assign bus.mem_q_i = mem_q;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        pl_we = 1'b0; pl_a = 10'd0; pl_d = 32'd0;
        bus.if_req_i = 1'b0; bus.if_addr_i = 16'h0055;
        bus.ex_req_i = 1'b0; bus.ex_we_i = 1'b0;
        bus.ex_addr_i = 16'h0000; bus.ex_wdata_i = 32'h0000_0000;

        // --- reset held, requests active: everything quiet
        cyc();
        bus.if_req_i = 1'b1; bus.ex_req_i = 1'b1; bus.ex_we_i = 1'b1;
        bus.ex_wdata_i = 32'hCAFE_F00D;
        #1;
        chk("rst_if_gnt", bus.if_gnt_o, 1'b0);
        chk("rst_ex_gnt", bus.ex_gnt_o, 1'b0);
        chk("rst_mem_w", bus.mem_w_o, 1'b0);
        chk("rst_mem_a", bus.mem_a_o, 16'h0000);
        chk("rst_if_valid", bus.if_valid_o, 1'b0);
        chk("rst_ex_valid", bus.ex_valid_o, 1'b0);
        chk("rst_if_rdata", bus.if_rdata_o, 32'h0000_0000);
        chk("rst_ex_rdata", bus.ex_rdata_o, 32'h0000_0000);

        // preload memory while still in reset
        pl_we = 1'b1; pl_a = 10'd16; pl_d = 32'hDEAD_BEEF;
        cyc(); pl_a = 10'd0; pl_d = 32'h1111_0000;
        cyc(); pl_a = 10'd1; pl_d = 32'h2222_0001;
        cyc(); pl_a = 10'd2; pl_d = 32'h3333_0002;
        cyc(); pl_we = 1'b0;
        bus.if_req_i = 1'b0; bus.ex_req_i = 1'b0; bus.ex_we_i = 1'b0;

        // --- release reset, no requests
        cyc();
        rst = 1'b1;
        #1;
        chk("rel_if_gnt", bus.if_gnt_o, 1'b0);
        chk("rel_ex_gnt", bus.ex_gnt_o, 1'b0);
        chk("rel_mem_a", bus.mem_a_o, 16'h0055);
        chk("rel_mem_w", bus.mem_w_o, 1'b0);
        chk("rel_if_valid", bus.if_valid_o, 1'b0);
        chk("rel_ex_valid", bus.ex_valid_o, 1'b0);

        // --- IF only read at 0x0010
        cyc();
        bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0010;
        #1;
        chk("if_gnt", bus.if_gnt_o, 1'b1);
        chk("if_ex_gnt", bus.ex_gnt_o, 1'b0);
        chk("if_mem_a", bus.mem_a_o, 16'h0010);
        chk("if_mem_w", bus.mem_w_o, 1'b0);
        cyc();
        bus.if_req_i = 1'b0;
        #1;
        chk("if_valid", bus.if_valid_o, 1'b1);
        chk("if_rdata", bus.if_rdata_o, 32'hDEAD_BEEF);
        chk("if_ex_valid", bus.ex_valid_o, 1'b0);
        cyc();
        #1;
        chk("if_valid_drop", bus.if_valid_o, 1'b0);
        chk("if_rdata_zero", bus.if_rdata_o, 32'h0000_0000);

        // --- EX store with IF also requesting: EX wins
        bus.ex_req_i = 1'b1; bus.ex_we_i = 1'b1;
        bus.ex_addr_i = 16'h0200; bus.ex_wdata_i = 32'h1234_5678;
        bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0001;
        #1;
        chk("st_ex_gnt", bus.ex_gnt_o, 1'b1);
        chk("st_if_gnt", bus.if_gnt_o, 1'b0);
        chk("st_mem_a", bus.mem_a_o, 16'h0200);
        chk("st_mem_w", bus.mem_w_o, 1'b1);
        chk("st_mem_d", bus.mem_d_o, 32'h1234_5678);
        // --- EX load back from 0x0200
        cyc();
        bus.ex_we_i = 1'b0; bus.if_req_i = 1'b0;
        #1;
        chk("ld_ex_gnt", bus.ex_gnt_o, 1'b1);
        chk("ld_mem_w", bus.mem_w_o, 1'b0);
        chk("ld_mem_a", bus.mem_a_o, 16'h0200);
        chk("st_ack_valid", bus.ex_valid_o, 1'b1);
        chk("st_ack_rdata", bus.ex_rdata_o, 32'h0000_0000);
        cyc();
        bus.ex_req_i = 1'b0;
        #1;
        chk("ld_valid", bus.ex_valid_o, 1'b1);
        chk("ld_rdata", bus.ex_rdata_o, 32'h1234_5678);
        chk("ld_if_valid", bus.if_valid_o, 1'b0);
        chk("ld_ex_gnt_off", bus.ex_gnt_o, 1'b0);

        // --- back-to-back IF reads 0,1,2
        cyc();
        bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0000;
        #1;
        chk("b2b_gnt0", bus.if_gnt_o, 1'b1);
        chk("b2b_nvalid", bus.if_valid_o, 1'b0);
        cyc();
        bus.if_addr_i = 16'h0001;
        #1;
        chk("b2b_gnt1", bus.if_gnt_o, 1'b1);
        chk("b2b_valid0", bus.if_valid_o, 1'b1);
        chk("b2b_data0", bus.if_rdata_o, 32'h1111_0000);
        cyc();
        bus.if_addr_i = 16'h0002;
        #1;
        chk("b2b_gnt2", bus.if_gnt_o, 1'b1);
        chk("b2b_valid1", bus.if_valid_o, 1'b1);
        chk("b2b_data1", bus.if_rdata_o, 32'h2222_0001);
        cyc();
        bus.if_req_i = 1'b0;
        #1;
        chk("b2b_valid2", bus.if_valid_o, 1'b1);
        chk("b2b_data2", bus.if_rdata_o, 32'h3333_0002);
        cyc();
        #1;
        chk("b2b_end", bus.if_valid_o, 1'b0);

        // --- contention: both request continuously
        for (int k = 0; k < 8; k++) begin
            cyc();
            bus.ex_req_i = 1'b1; bus.ex_we_i = 1'b0; bus.ex_addr_i = 16'h0200;
            bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0010;
            #1;
            exp_gnt = (GUARD && ((k % 4) == 3)) ? 2'b10 : 2'b01;
            chk("cont_gnt", {bus.if_gnt_o, bus.ex_gnt_o}, exp_gnt);
        end
        cyc();
        bus.ex_req_i = 1'b0; bus.if_req_i = 1'b0;

        // --- reset asserted right after an IF grant
        cyc();
        bus.if_req_i = 1'b1; bus.if_addr_i = 16'h0010;
        #1;
        chk("mf_gnt", bus.if_gnt_o, 1'b1);
        #3;
        rst = 1'b0;
        bus.if_req_i = 1'b0;
        cyc();
        chk("mf_valid_rst", bus.if_valid_o, 1'b0);
        chk("mf_rdata_rst", bus.if_rdata_o, 32'h0000_0000);
        cyc();
        rst = 1'b1;
        #1;
        chk("mf_valid_rel", bus.if_valid_o, 1'b0);
        cyc();
        chk("mf_valid_after", bus.if_valid_o, 1'b0);
        chk("mf_ex_valid_after", bus.ex_valid_o, 1'b0);

        if (bad != 0) begin
            $error("TEST FAILED: total=%0d bad=%0d", total, bad);
        end else begin
            $display("TEST PASSED: total=%0d bad=%0d", total, bad);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
